picomem_arb_2_1: RTL and testbench

- Two-master-to-one-slave PicoMem arbiter; the converging counterpart of the 1:4 address-decode muxes.
- Lets a second initiator (DMA or debug bridge) share a slave port (e.g. PSRAM, or the CPU's top-level bus) with the CPU.
- Registered grant with round-robin or fixed priority; a grant is held for the whole transaction.
- Optional timeout completes a hung transaction with an error word.

---
 rtl/picomem_arb_2_1.sv | 164 ++++++++++++++++
 tb/tb_picomem_arb_2_1.sv | 396 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/picomem_arb_2_1.sv
// Purpose: two PicoMem masters share one slave port; the grant is held for the whole transaction.
// Latency: a request seen in cycle N reaches the slave in N+1; completion returns to the master combinationally.
// Backpressure: a waiting master holds valid until granted and served; a hung slave is cut off by the timeout.
module picomem_arb_2_1 #(
    parameter int unsigned PRIORITY       = 0,
    parameter int unsigned TIMEOUT_CYCLES = 1023,
    parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        picom0_valid,
    output logic        picom0_ready,
    input  logic [31:0] picom0_addr,
    input  logic [31:0] picom0_wdata,
    input  logic [3:0]  picom0_wstrb,
    output logic [31:0] picom0_rdata,

    input  logic        picom1_valid,
    output logic        picom1_ready,
    input  logic [31:0] picom1_addr,
    input  logic [31:0] picom1_wdata,
    input  logic [3:0]  picom1_wstrb,
    output logic [31:0] picom1_rdata,

    output logic        picos_valid,
    input  logic        picos_ready,
    output logic [31:0] picos_addr,
    output logic [31:0] picos_wdata,
    output logic [3:0]  picos_wstrb,
    input  logic [31:0] picos_rdata,

    output logic [1:0]  grant,
    output logic        timeout_pulse
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_BUSY0 = 2'b01,
        ST_BUSY1 = 2'b10
    } state_t;

    // Timeout limit lives in a 16-bit counter; a limit of zero turns the watchdog off.
    localparam logic [15:0] TMO_LIMIT  = 16'(TIMEOUT_CYCLES);
    localparam bit          TMO_ENABLE = (TIMEOUT_CYCLES != 0);
    localparam bit          FIXED_PRIO = (PRIORITY != 0);

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_last_m1;      // 1 when master 1 was the most recent owner
    logic [15:0] r_cnt;          // BUSY cycles spent waiting on the slave

    logic        w_busy;
    logic        w_sel_m1;
    logic        w_own_valid;
    logic        w_pick_m1;
    logic        w_tmo_hit;
    logic        w_timeout;
    logic        w_end;

    assign w_busy      = (r_state != ST_IDLE);
    assign w_sel_m1    = (r_state == ST_BUSY1);
    assign w_own_valid = w_sel_m1 ? picom1_valid : picom0_valid;

    // The limit cycle suppresses the slave request regardless of picos_ready, so
    // picos_valid never depends combinationally on picos_ready.
    assign w_tmo_hit   = TMO_ENABLE && w_busy && (r_cnt == TMO_LIMIT);

    // A real slave completion on the limit cycle beats the timeout.
    assign w_timeout   = w_tmo_hit && w_own_valid && !picos_ready;

    // Transaction ends on completion, timeout, or the owner abandoning its request.
    assign w_end       = w_busy && (picos_ready || !w_own_valid || w_timeout);

    // Arbitration between simultaneous requests seen while idle.
    always_comb begin
        w_pick_m1 = 1'b0;
        if (picom0_valid && picom1_valid) begin
            w_pick_m1 = FIXED_PRIO ? 1'b0 : !r_last_m1;
        end else begin
            w_pick_m1 = picom1_valid;
        end
    end

    // State register: owner of the slave port.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: grant on any request, release at the end of the transaction.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (picom0_valid || picom1_valid) begin
                    w_state_nxt = w_pick_m1 ? ST_BUSY1 : ST_BUSY0;
                end
            end
            ST_BUSY0, ST_BUSY1: begin
                if (w_end) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Round-robin history and watchdog counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last_m1 <= 1'b1;
            r_cnt     <= 16'd0;
        end else begin
            if ((r_state == ST_IDLE) && (w_state_nxt != ST_IDLE)) begin
                r_last_m1 <= (w_state_nxt == ST_BUSY1);
            end
            if (!w_busy || w_end) begin
                r_cnt <= 16'd0;
            end else if (TMO_ENABLE) begin
                r_cnt <= r_cnt + 16'd1;
            end
        end
    end

    // Outputs: forward the owner's request to the slave and the slave's response to the owner.
    always_comb begin
        grant         = {r_state == ST_BUSY1, r_state == ST_BUSY0};
        picos_valid   = 1'b0;
        picos_addr    = 32'd0;
        picos_wdata   = 32'd0;
        picos_wstrb   = 4'd0;
        picom0_ready  = 1'b0;
        picom0_rdata  = 32'd0;
        picom1_ready  = 1'b0;
        picom1_rdata  = 32'd0;
        timeout_pulse = w_timeout;
        case (r_state)
            ST_BUSY0: begin
                picos_valid  = picom0_valid && !w_tmo_hit;
                picos_addr   = picom0_addr;
                picos_wdata  = picom0_wdata;
                picos_wstrb  = picom0_wstrb;
                picom0_ready = picos_ready || w_timeout;
                picom0_rdata = w_timeout ? ERR_RDATA : picos_rdata;
            end
            ST_BUSY1: begin
                picos_valid  = picom1_valid && !w_tmo_hit;
                picos_addr   = picom1_addr;
                picos_wdata  = picom1_wdata;
                picos_wstrb  = picom1_wstrb;
                picom1_ready = picos_ready || w_timeout;
                picom1_rdata = w_timeout ? ERR_RDATA : picos_rdata;
            end
            default: begin
                picos_valid  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_picomem_arb_2_1.sv
`timescale 1ns/1ps
module tb_picomem_arb_2_1;

    localparam logic [31:0] ERR = 32'hDEAD_BEEF;
    localparam int          TMO = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Index [d] selects the instance: d=0 round-robin, d=1 fixed priority; [m] selects the master.
    logic        mv  [2][2];
    logic        mr  [2][2];
    logic [31:0] ma  [2][2];
    logic [31:0] mw  [2][2];
    logic [3:0]  ms  [2][2];
    logic [31:0] mrd [2][2];
    logic        pv  [2];
    logic        pr  [2];
    logic [31:0] pa  [2];
    logic [31:0] pw  [2];
    logic [3:0]  ps  [2];
    logic [31:0] prd [2];
    logic [1:0]  gr  [2];
    logic        tp  [2];

    int checks   = 0;
    int failures = 0;

    for (genvar d = 0; d < 2; d++) begin : g_dut
        picomem_arb_2_1 #(
            .PRIORITY       (d),
            .TIMEOUT_CYCLES (TMO),
            .ERR_RDATA      (ERR)
        ) u_dut (
            .clk           (clk),
            .reset         (rst),
            .picom0_valid  (mv[d][0]),
            .picom0_ready  (mr[d][0]),
            .picom0_addr   (ma[d][0]),
            .picom0_wdata  (mw[d][0]),
            .picom0_wstrb  (ms[d][0]),
            .picom0_rdata  (mrd[d][0]),
            .picom1_valid  (mv[d][1]),
            .picom1_ready  (mr[d][1]),
            .picom1_addr   (ma[d][1]),
            .picom1_wdata  (mw[d][1]),
            .picom1_wstrb  (ms[d][1]),
            .picom1_rdata  (mrd[d][1]),
            .picos_valid   (pv[d]),
            .picos_ready   (pr[d]),
            .picos_addr    (pa[d]),
            .picos_wdata   (pw[d]),
            .picos_wstrb   (ps[d]),
            .picos_rdata   (prd[d]),
            .grant         (gr[d]),
            .timeout_pulse (tp[d])
        );
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_m(input int d, input int m, input logic v,
                         input logic [31:0] a, input logic [31:0] w, input logic [3:0] s);
        mv[d][m] = v;
        ma[d][m] = a;
        mw[d][m] = w;
        ms[d][m] = s;
    endtask

    task automatic clear_all();
        for (int d = 0; d < 2; d++) begin
            set_m(d, 0, 1'b0, 32'd0, 32'd0, 4'd0);
            set_m(d, 1, 1'b0, 32'd0, 32'd0, 4'd0);
            pr[d]  = 1'b0;
            prd[d] = 32'd0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_all();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_all();
        set_m(0, 0, 1'b1, 32'h1111_0000, 32'h2222_0000, 4'hF);
        set_m(1, 1, 1'b1, 32'h3333_0000, 32'h4444_0000, 4'h3);
        pr[0] = 1'b1; prd[0] = 32'hABCD_0001;
        pr[1] = 1'b1; prd[1] = 32'hABCD_0002;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if ({gr[d], pv[d], mr[d][0], mr[d][1], tp[d]} !== 6'd0) begin
                failures++;
                $display("FAIL reset_ctrl dut%0d got=%b exp=000000", d, {gr[d], pv[d], mr[d][0], mr[d][1], tp[d]});
            end
            checks++;
            if ({pa[d], pw[d], ps[d], mrd[d][0], mrd[d][1]} !== 132'd0) begin
                failures++;
                $display("FAIL reset_data dut%0d got=%h exp=0", d, {pa[d], pw[d], ps[d], mrd[d][0], mrd[d][1]});
            end
        end
        tick();
        clear_all();
        rst = 1'b0;
    endtask

    task automatic test_read();
        tick();
        set_m(0, 0, 1'b1, 32'h4000_0010, 32'd0, 4'd0);
        @(negedge clk);
        checks++;
        if ({gr[0], pv[0]} !== 3'b000) begin
            failures++;
            $display("FAIL read_req_cycle got=%b exp=000", {gr[0], pv[0]});
        end
        tick();
        @(negedge clk);
        checks++;
        if ({gr[0], pv[0], pa[0], mr[0][0]} !== {2'b01, 1'b1, 32'h4000_0010, 1'b0}) begin
            failures++;
            $display("FAIL read_grant got=%h exp=%h", {gr[0], pv[0], pa[0], mr[0][0]}, {2'b01, 1'b1, 32'h4000_0010, 1'b0});
        end
        repeat (2) begin
            tick();
            @(negedge clk);
            checks++;
            if ({gr[0], mr[0][0]} !== 3'b010) begin
                failures++;
                $display("FAIL read_wait got=%b exp=010", {gr[0], mr[0][0]});
            end
        end
        tick();
        pr[0]  = 1'b1;
        prd[0] = 32'h1234_5678;
        @(negedge clk);
        checks++;
        if ({mr[0][0], mrd[0][0], tp[0], mr[0][1]} !== {1'b1, 32'h1234_5678, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL read_done got=%h exp=%h", {mr[0][0], mrd[0][0], tp[0], mr[0][1]}, {1'b1, 32'h1234_5678, 1'b0, 1'b0});
        end
        tick();
        clear_all();
        @(negedge clk);
        checks++;
        if (gr[0] !== 2'b00) begin
            failures++;
            $display("FAIL read_release got=%b exp=00", gr[0]);
        end
    endtask

    task automatic test_timeout();
        tick();
        set_m(0, 1, 1'b1, 32'h8000_0040, 32'd0, 4'd0);
        prd[0] = 32'h5555_AAAA;
        @(negedge clk);
        for (int c = 0; c < TMO; c++) begin
            tick();
            @(negedge clk);
            checks++;
            if ({gr[0], pv[0], mr[0][1], tp[0]} !== 5'b10100) begin
                failures++;
                $display("FAIL tmo_busy c=%0d got=%b exp=10100", c, {gr[0], pv[0], mr[0][1], tp[0]});
            end
        end
        tick();
        @(negedge clk);
        checks++;
        if ({gr[0], pv[0], mr[0][1], mrd[0][1], tp[0]} !== {2'b10, 1'b0, 1'b1, ERR, 1'b1}) begin
            failures++;
            $display("FAIL tmo_fire got=%h exp=%h", {gr[0], pv[0], mr[0][1], mrd[0][1], tp[0]}, {2'b10, 1'b0, 1'b1, ERR, 1'b1});
        end
        tick();
        clear_all();
        @(negedge clk);
        checks++;
        if ({gr[0], tp[0]} !== 3'b000) begin
            failures++;
            $display("FAIL tmo_after got=%b exp=000", {gr[0], tp[0]});
        end
    endtask

    task automatic test_ready_on_timeout();
        tick();
        set_m(0, 0, 1'b1, 32'h8000_0080, 32'd0, 4'd0);
        repeat (TMO + 1) tick();
        pr[0]  = 1'b1;
        prd[0] = 32'hCAFE_F00D;
        @(negedge clk);
        checks++;
        if ({pv[0], mr[0][0], mrd[0][0], tp[0]} !== {1'b0, 1'b1, 32'hCAFE_F00D, 1'b0}) begin
            failures++;
            $display("FAIL ready_wins got=%h exp=%h", {pv[0], mr[0][0], mrd[0][0], tp[0]}, {1'b0, 1'b1, 32'hCAFE_F00D, 1'b0});
        end
        tick();
        clear_all();
        @(negedge clk);
        checks++;
        if (gr[0] !== 2'b00) begin
            failures++;
            $display("FAIL ready_wins_release got=%b exp=00", gr[0]);
        end
    endtask

    task automatic test_write_reset();
        tick();
        set_m(0, 0, 1'b1, 32'h0000_0100, 32'h55AA_55AA, 4'b0011);
        tick();
        @(negedge clk);
        checks++;
        if ({gr[0], pv[0], pa[0], pw[0], ps[0]} !== {2'b01, 1'b1, 32'h0000_0100, 32'h55AA_55AA, 4'b0011}) begin
            failures++;
            $display("FAIL write_fwd got=%h exp=%h", {gr[0], pv[0], pa[0], pw[0], ps[0]}, {2'b01, 1'b1, 32'h0000_0100, 32'h55AA_55AA, 4'b0011});
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({gr[0], pv[0], pw[0]} !== 35'd0) begin
            failures++;
            $display("FAIL async_reset got=%h exp=0", {gr[0], pv[0], pw[0]});
        end
        tick();
        tick();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (gr[0] !== 2'b00) begin
            failures++;
            $display("FAIL post_reset_idle got=%b exp=00", gr[0]);
        end
        tick();
        @(negedge clk);
        checks++;
        if ({gr[0], pw[0], ps[0]} !== {2'b01, 32'h55AA_55AA, 4'b0011}) begin
            failures++;
            $display("FAIL post_reset_regrant got=%h exp=%h", {gr[0], pw[0], ps[0]}, {2'b01, 32'h55AA_55AA, 4'b0011});
        end
        // Owner withdraws its request: no ready, back to idle on the next edge.
        tick();
        set_m(0, 0, 1'b0, 32'd0, 32'd0, 4'd0);
        @(negedge clk);
        checks++;
        if ({gr[0], pv[0], mr[0][0]} !== 4'b0100) begin
            failures++;
            $display("FAIL abort_cycle got=%b exp=0100", {gr[0], pv[0], mr[0][0]});
        end
        tick();
        @(negedge clk);
        checks++;
        if (gr[0] !== 2'b00) begin
            failures++;
            $display("FAIL abort_release got=%b exp=00", gr[0]);
        end
    endtask

    // Both masters request continuously and the slave completes at once.
    task automatic test_arb(input int d);
        logic [1:0] exp_g;
        do_reset();
        tick();
        set_m(d, 0, 1'b1, 32'h0000_1000, 32'd0, 4'd0);
        set_m(d, 1, 1'b1, 32'h0000_2000, 32'd0, 4'd0);
        pr[d]  = 1'b1;
        prd[d] = 32'h0BAD_F00D;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (c % 2 == 0)      exp_g = 2'b00;
            else if (d == 1)     exp_g = 2'b01;
            else if (c % 4 == 1) exp_g = 2'b01;
            else                 exp_g = 2'b10;
            checks++;
            if ({gr[d], mr[d][1], mr[d][0]} !== {exp_g, exp_g}) begin
                failures++;
                $display("FAIL arb dut%0d c=%0d got=%b exp=%b", d, c, {gr[d], mr[d][1], mr[d][0]}, {exp_g, exp_g});
            end
            tick();
        end
        clear_all();
    endtask

    task automatic test_random();
        int          owner [2];
        int          cnt   [2];
        int          last  [2];
        int          dly   [2];
        int          o;
        logic        nv [2][2];
        logic [31:0] na [2][2];
        logic [31:0] nw [2][2];
        logic [3:0]  ns [2][2];
        logic        er  [2];
        logic [31:0] erd [2];
        logic [1:0]  eg;
        logic        epv, etp, hit, mvo, tmo;
        logic [31:0] ea, ew;
        logic [3:0]  es;
        do_reset();
        for (int d = 0; d < 2; d++) begin
            owner[d] = -1; cnt[d] = 0; last[d] = 1; dly[d] = 0;
            for (int m = 0; m < 2; m++) begin
                nv[d][m] = 1'b0; na[d][m] = 32'd0; nw[d][m] = 32'd0; ns[d][m] = 4'd0;
            end
        end
        for (int cyc = 0; cyc < 1500; cyc++) begin
            tick();
            for (int d = 0; d < 2; d++) begin
                for (int m = 0; m < 2; m++) set_m(d, m, nv[d][m], na[d][m], nw[d][m], ns[d][m]);
                pr[d]  = (owner[d] >= 0) && (cnt[d] == dly[d]);
                prd[d] = $urandom();
            end
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                eg = 2'b00; epv = 1'b0; etp = 1'b0; ea = 32'd0; ew = 32'd0; es = 4'd0;
                er[0] = 1'b0; er[1] = 1'b0; erd[0] = 32'd0; erd[1] = 32'd0;
                hit = 1'b0; mvo = 1'b0; tmo = 1'b0; o = 0;
                if (owner[d] >= 0) begin
                    o      = owner[d];
                    mvo    = mv[d][o];
                    hit    = (cnt[d] == TMO);
                    tmo    = hit && mvo && !pr[d];
                    eg     = (o == 0) ? 2'b01 : 2'b10;
                    epv    = mvo && !hit;
                    ea     = ma[d][o];
                    ew     = mw[d][o];
                    es     = ms[d][o];
                    er[o]  = pr[d] || tmo;
                    erd[o] = tmo ? ERR : prd[d];
                    etp    = tmo;
                end
                checks++;
                if ({gr[d], pv[d], mr[d][0], mr[d][1], tp[d]} !== {eg, epv, er[0], er[1], etp}) begin
                    failures++;
                    $display("FAIL rand_ctrl dut%0d cyc=%0d got=%b exp=%b", d, cyc,
                             {gr[d], pv[d], mr[d][0], mr[d][1], tp[d]}, {eg, epv, er[0], er[1], etp});
                end
                checks++;
                if ({pa[d], pw[d], ps[d], mrd[d][0], mrd[d][1]} !== {ea, ew, es, erd[0], erd[1]}) begin
                    failures++;
                    $display("FAIL rand_data dut%0d cyc=%0d got=%h exp=%h", d, cyc,
                             {pa[d], pw[d], ps[d], mrd[d][0], mrd[d][1]}, {ea, ew, es, erd[0], erd[1]});
                end
                if (owner[d] < 0) begin
                    if (mv[d][0] || mv[d][1]) begin
                        if (mv[d][0] && mv[d][1]) o = (d == 1) ? 0 : 1 - last[d];
                        else                      o = mv[d][1] ? 1 : 0;
                        owner[d] = o;
                        last[d]  = o;
                        cnt[d]   = 0;
                        dly[d]   = $urandom_range(0, 11);
                    end
                end else if (pr[d] || !mvo || tmo) begin
                    owner[d] = -1;
                    cnt[d]   = 0;
                end else begin
                    cnt[d]++;
                end
                for (int m = 0; m < 2; m++) begin
                    nv[d][m] = mv[d][m]; na[d][m] = ma[d][m]; nw[d][m] = mw[d][m]; ns[d][m] = ms[d][m];
                    if (er[m] || !mv[d][m]) begin
                        if ($urandom_range(0, 3) < (er[m] ? 2 : 1)) begin
                            nv[d][m] = 1'b1;
                            na[d][m] = $urandom();
                            nw[d][m] = $urandom();
                            ns[d][m] = 4'($urandom_range(0, 15));
                        end else begin
                            nv[d][m] = 1'b0;
                        end
                    end
                end
            end
        end
        tick();
        clear_all();
    endtask

    initial begin
        test_reset();
        test_read();
        test_timeout();
        test_ready_on_timeout();
        test_write_reset();
        test_arb(0);
        test_arb(1);
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
